// File: rtl/prog_clk_div_pkg.sv
// Shared constants for the programmable clock divider: parameter defaults and
// the widest counter the block is meant to be built with.
package prog_clk_div_pkg;

  localparam int DEF_WIDTH     = 3;
  localparam int DEF_RESET_DIV = 7;
  localparam int MAX_WIDTH     = 16;

endpackage : prog_clk_div_pkg

// File: rtl/prog_clk_div.sv
// Programmable 50%-duty clock divider: op1 toggles every div_q+1 enabled cycles,
// with divisor updates deferred to half-period boundaries so no runt phases occur.
module prog_clk_div
  import prog_clk_div_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RESET_DIV = DEF_RESET_DIV
) (
  input  logic             ip1,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             op1,
  output logic             tick
);

  localparam logic [WIDTH-1:0] RESET_DIV_V = WIDTH'(RESET_DIV);

  logic [WIDTH-1:0] ctr_q,     ctr_d;
  logic [WIDTH-1:0] div_q,     div_d;
  logic [WIDTH-1:0] div_s_q,   div_s_d;
  logic             pending_q, pending_d;
  logic             op1_q,     op1_d;
  logic             tick_q,    tick_d;
  logic             tc;

  assign tc = en && (ctr_q == div_q);

  // NOTE: every next-state signal gets its hold value first, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ctr_d     = ctr_q;
    div_d     = div_q;
    div_s_d   = div_s_q;
    pending_d = pending_q;
    op1_d     = op1_q;
    tick_d    = 1'b0;

    if (!en) begin
      // Frozen: adopt the newest requested divisor right away and rearm the count.
      ctr_d     = '0;
      pending_d = 1'b0;
      if (div_load) begin
        div_d   = div_in;
        div_s_d = div_in;
      end else if (pending_q) begin
        div_d   = div_s_q;
      end
    end else if (tc) begin
      ctr_d     = '0;
      op1_d     = ~op1_q;
      tick_d    = 1'b1;
      pending_d = 1'b0;
      if (div_load) begin
        div_d   = div_in;
        div_s_d = div_in;
      end else if (pending_q) begin
        div_d   = div_s_q;
      end
    end else begin
      ctr_d = ctr_q + WIDTH'(1);
      if (div_load) begin
        div_s_d   = div_in;
        pending_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge ip1) begin
    if (reset) begin
      ctr_q     <= '0;
      div_q     <= RESET_DIV_V;
      div_s_q   <= RESET_DIV_V;
      pending_q <= 1'b0;
      op1_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      div_q     <= div_d;
      div_s_q   <= div_s_d;
      pending_q <= pending_d;
      op1_q     <= op1_d;
      tick_q    <= tick_d;
    end
  end

  assign div_busy = pending_q;
  assign op1      = op1_q;
  assign tick     = tick_q;

endmodule : prog_clk_div
